// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per clock.
// Takes a packed BCD value on start and returns the binary value with a done pulse.
module bcd2bin_seq #(
    parameter int unsigned DIGITS = 6,
    parameter int unsigned BIN_W  = 20,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d, sr_step;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flag_q, flag_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               in_err;

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                in_err = 1'b1;
            end
        end
    end

    // Shift right, then pull every BCD nibble >= 8 back down by 3.
    always_comb begin
        sr_step = sr_q >> 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sr_step[BIN_W + 4*i +: 4] >= 4'd8) begin
                sr_step[BIN_W + 4*i +: 4] = sr_step[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sr_d    = {bcd_in, {BIN_W{1'b0}}};
                    flag_d  = in_err;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StConv;
                end
            end
            StConv: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bin_d   = flag_q ? '0 : sr_step[BIN_W-1:0];
                    err_d   = flag_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bin  = bin_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: table of conversions plus hand-written
// sequences for restart-ignore, held start and mid-run reset.
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] bcd_in;
    logic        busy;
    logic        done;
    logic [19:0] bin;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd2bin_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .bin    (bin),
        .err    (err)
    );

    typedef struct {
        logic [23:0] bcd;
        logic [19:0] bin;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one conversion and watch 40 cycles. With disturb set, start is
    // re-pulsed and bcd_in scrambled at cycle 5 of the run.
    task automatic run_conv(input string tag, input logic [23:0] v, input logic [19:0] exp_bin,
                            input logic exp_err, input bit disturb);
        int          busy_cnt = 0;
        int          done_at  = -1;
        int          n_done   = 0;
        logic [19:0] prev_bin;
        logic        prev_err;
        logic        held_ok  = 1'b1;
        logic [19:0] got_bin  = '0;
        logic        got_err  = 1'b0;
        @(negedge clk);
        prev_bin = bin;
        prev_err = err;
        bcd_in   = v;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = k;
                    got_bin = bin;
                    got_err = err;
                end
            end else if (done_at < 0 && (bin !== prev_bin || err !== prev_err)) begin
                held_ok = 1'b0;
            end
            if (disturb && k == 5) begin
                start  = 1'b1;
                bcd_in = 24'h999999;
            end else if (disturb && k == 6) begin
                start  = 1'b0;
                bcd_in = 24'h555555;
            end
            @(negedge clk);
        end
        check({tag, ".latency"}, done_at, 20);
        check({tag, ".busy_cycles"}, busy_cnt, 20);
        check({tag, ".done_count"}, n_done, 1);
        check({tag, ".bin"}, {12'h0, got_bin}, {12'h0, exp_bin});
        check({tag, ".err"}, {31'h0, got_err}, {31'h0, exp_err});
        check({tag, ".hold"}, {31'h0, held_ok}, 32'h1);
    endtask

    initial begin
        vecs[0] = '{24'h999999, 20'hF423F, 1'b0};
        vecs[1] = '{24'h123456, 20'h1E240, 1'b0};
        vecs[2] = '{24'h065536, 20'h10000, 1'b0};
        vecs[3] = '{24'h000000, 20'h00000, 1'b0};
        vecs[4] = '{24'h12A456, 20'h00000, 1'b1};
        vecs[5] = '{24'h000001, 20'h00001, 1'b0};
        vecs[6] = '{24'h000099, 20'h00063, 1'b0};
        vecs[7] = '{24'h100000, 20'h186A0, 1'b0};
        vecs[8] = '{24'h00000F, 20'h00000, 1'b1};

        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.busy", {31'h0, busy}, 32'h0);
        check("reset.done", {31'h0, done}, 32'h0);
        check("reset.bin", {12'h0, bin}, 32'h0);
        check("reset.err", {31'h0, err}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].err, 1'b0);
        end

        // Start ignored mid-run; result comes from the captured value.
        run_conv("restart", 24'h123456, 20'h1E240, 1'b0, 1'b1);

        // Start held high: one result every 21 cycles.
        begin
            int done_idx[$];
            int bad_bin = 0;
            @(negedge clk);
            bcd_in = 24'h000010;
            start  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            for (int k = 0; k < 70; k++) begin
                if (done) begin
                    done_idx.push_back(k);
                    if (bin !== 20'h0000A) bad_bin++;
                end
                @(negedge clk);
            end
            start = 1'b0;
            check("held.done_count", done_idx.size(), 3);
            if (done_idx.size() == 3) begin
                check("held.first", done_idx[0], 20);
                check("held.gap1", done_idx[1] - done_idx[0], 21);
                check("held.gap2", done_idx[2] - done_idx[1], 21);
            end
            check("held.bin_bad", bad_bin, 0);
            for (int k = 0; k < 30 && busy; k++) @(negedge clk);
            check("held.drain", {31'h0, busy}, 32'h0);
            repeat (2) @(negedge clk);
        end

        // Reset at cycle 10 aborts the conversion and clears outputs.
        begin
            int n_done = 0;
            @(negedge clk);
            bcd_in = 24'h999999;
            start  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            repeat (10) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            check("abort.busy", {31'h0, busy}, 32'h0);
            check("abort.bin", {12'h0, bin}, 32'h0);
            check("abort.err", {31'h0, err}, 32'h0);
            for (int k = 0; k < 30; k++) begin
                if (done) n_done++;
                @(negedge clk);
            end
            check("abort.no_done", n_done, 0);
        end
        run_conv("after_abort", 24'h999999, 20'hF423F, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
